// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline stall/flush controller
// and the stage registers it steers.
package pipe_ctrl_definitions;

  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_DRAIN,
    CTRL_HALTED
  } ctrl_state_t;

  // Canonical NOP (addi x0, x0, 0) loaded by a flushed stage register.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
    logic halted;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_OUT_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0, halted: 1'b0
  };

  localparam ctrl_out_t CTRL_OUT_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b1, halted: 1'b0
  };

  localparam ctrl_out_t CTRL_OUT_HALT = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0, halted: 1'b1
  };

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/handshake inputs and stage-control outputs of pipeline_ctrl.
// master = the pipeline datapath, slave = the controller.
interface pipeline_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_MemRead;
  logic        ex_redirect;
  logic        imem_ready;
  logic        mem_req;
  logic        mem_ready;
  logic        halt_req;
  logic        resume;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_bubble;
  logic        halted;
  logic        mem_fault;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead,
           ex_redirect, imem_ready, mem_req, mem_ready, halt_req, resume,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_flush, mem_wb_bubble, halted, mem_fault, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead,
           ex_redirect, imem_ready, mem_req, mem_ready, halt_req, resume,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_flush, mem_wb_bubble, halted, mem_fault, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard: the EX-stage load writes a register the decode-stage
// instruction reads. x0 never creates a dependency.
module load_use_detect
  import pipe_ctrl_definitions::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       lu_o
);
  logic hit1, hit2;

  assign hit1 = id_uses_rs1_i && (ex_rd_i == id_rs1_i);
  assign hit2 = id_uses_rs2_i && (ex_rd_i == id_rs2_i);
  assign lu_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) && (hit1 || hit2);
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard priority mux,
// halt/drain FSM, data-memory timeout fault and stall-cycle counter.
module pipeline_ctrl
  import pipe_ctrl_definitions::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned DMEM_TIMEOUT = 256
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WW = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;

  ctrl_state_t state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_fault_q, mem_fault_d;
  logic          halt_pend_q, halt_pend_d;
  logic [31:0]   stall_q, stall_d;

  logic      freeze, lu, timeout;
  ctrl_out_t out;

  assign freeze  = bus.mem_req && !bus.mem_ready;
  assign timeout = freeze && (wait_cnt_q == WW'(DMEM_TIMEOUT - 1));

  load_use_detect u_lu (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_uses_rs1_i (bus.id_uses_rs1),
    .id_uses_rs2_i (bus.id_uses_rs2),
    .ex_rd_i       (bus.ex_rd),
    .ex_mem_read_i (bus.ex_MemRead),
    .lu_o          (lu)
  );

  // Output priority: freeze > redirect > load-use > fetch miss.
  always_comb begin
    out = CTRL_OUT_RUN;
    unique case (state_q)
      CTRL_RUN: begin
        if (freeze) begin
          out = CTRL_OUT_FREEZE;
        end else if (bus.ex_redirect) begin
          out.if_id_flush = 1'b1;
          out.id_ex_flush = 1'b1;
        end else if (lu) begin
          out.pc_en       = 1'b0;
          out.if_id_en    = 1'b0;
          out.id_ex_flush = 1'b1;
        end else if (!bus.imem_ready) begin
          out.pc_en       = 1'b0;
          out.if_id_flush = 1'b1;
        end
      end
      CTRL_DRAIN: begin
        if (freeze) begin
          out = CTRL_OUT_FREEZE;
        end else begin
          out.pc_en       = 1'b0;
          out.if_id_flush = 1'b1;
        end
      end
      CTRL_HALTED: out = CTRL_OUT_HALT;
      default:     out = CTRL_OUT_RUN;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halt_pend_d = halt_pend_q;
    mem_fault_d = mem_fault_q;
    wait_cnt_d  = freeze ? wait_cnt_q + 1'b1 : '0;
    stall_d     = (!out.pc_en && state_q != CTRL_HALTED) ? stall_q + 32'd1 : stall_q;
    unique case (state_q)
      CTRL_RUN: begin
        if (halt_pend_q && !freeze) state_d = CTRL_DRAIN;
        if (bus.halt_req) halt_pend_d = 1'b1;
      end
      CTRL_DRAIN: begin
        if (!freeze) begin
          if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
            state_d     = CTRL_HALTED;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      CTRL_HALTED: begin
        if (bus.resume && !bus.halt_req && !mem_fault_q) begin
          state_d     = CTRL_RUN;
          halt_pend_d = 1'b0;
        end
      end
      default: state_d = CTRL_RUN;
    endcase
    // A hung data access wins over every other transition.
    if (timeout) begin
      state_d     = CTRL_HALTED;
      mem_fault_d = 1'b1;
      drain_cnt_d = '0;
      wait_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CTRL_RUN;
      drain_cnt_q <= '0;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
      halt_pend_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
      halt_pend_q <= halt_pend_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.pc_en         = out.pc_en;
  assign bus.if_id_en      = out.if_id_en;
  assign bus.id_ex_en      = out.id_ex_en;
  assign bus.ex_mem_en     = out.ex_mem_en;
  assign bus.mem_wb_en     = out.mem_wb_en;
  assign bus.if_id_flush   = out.if_id_flush;
  assign bus.id_ex_flush   = out.id_ex_flush;
  assign bus.mem_wb_bubble = out.mem_wb_bubble;
  assign bus.halted        = out.halted;
  assign bus.mem_fault     = mem_fault_q;
  assign bus.stall_cycles  = stall_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed + random bench for pipeline_ctrl against a rule-level reference model.
module tb_pipeline_ctrl;
  localparam int DC = 4;
  localparam int TO = 8;

  // Output vector order: pc, if_id, id_ex, ex_mem, mem_wb, if_flush, id_flush, bubble, halted
  localparam logic [8:0] V_RUN    = 9'b111110000;
  localparam logic [8:0] V_FREEZE = 9'b000000010;
  localparam logic [8:0] V_HALT   = 9'b000000001;
  localparam logic [8:0] V_FETCH  = 9'b011111000;
  localparam logic [8:0] V_REDIR  = 9'b111111100;
  localparam logic [8:0] V_LU     = 9'b001110100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus();
  pipeline_ctrl #(.DRAIN_CYCLES(DC), .DMEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: mode 0=running, 1=draining, 2=halted
  int          m_mode, m_drain, m_wait;
  bit          m_fault, m_pend;
  logic [31:0] m_stall;

  function automatic logic [8:0] obs();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble, bus.halted};
  endfunction

  function automatic logic [8:0] expect_out();
    bit fz, lu;
    fz = bus.mem_req && !bus.mem_ready;
    lu = bus.ex_MemRead && (bus.ex_rd != 0) &&
         ((bus.id_uses_rs1 && bus.ex_rd == bus.id_rs1) ||
          (bus.id_uses_rs2 && bus.ex_rd == bus.id_rs2));
    if (m_mode == 2) return V_HALT;
    if (fz) return V_FREEZE;
    if (m_mode == 1) return V_FETCH;
    if (bus.ex_redirect) return V_REDIR;
    if (lu) return V_LU;
    if (!bus.imem_ready) return V_FETCH;
    return V_RUN;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_drain = 0; m_wait = 0; m_fault = 0; m_pend = 0; m_stall = 0;
  endtask

  task automatic model_step(input logic [8:0] e);
    bit fz, to_hit;
    fz = bus.mem_req && !bus.mem_ready;
    if (m_mode != 2 && !e[8]) m_stall = m_stall + 1;
    to_hit = fz && (m_wait == TO - 1);
    m_wait = fz ? m_wait + 1 : 0;
    case (m_mode)
      0: begin
        if (m_pend && !fz) m_mode = 1;
        if (bus.halt_req) m_pend = 1;
      end
      1: if (!fz) begin
        if (m_drain == DC - 1) begin m_mode = 2; m_drain = 0; end
        else m_drain++;
      end
      default: if (bus.resume && !bus.halt_req && !m_fault) begin m_mode = 0; m_pend = 0; end
    endcase
    if (to_hit) begin m_fault = 1; m_mode = 2; m_drain = 0; m_wait = 0; end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    n_checks++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, x);
    end
  endtask

  // Compare the current cycle against the model, then advance one clock.
  task automatic tick(input string tag);
    logic [8:0] e;
    #1;
    e = expect_out();
    chk({tag, "/outs"}, 32'(obs()), 32'(e));
    chk({tag, "/fault"}, 32'(bus.mem_fault), 32'(m_fault));
    chk({tag, "/stall"}, bus.stall_cycles, m_stall);
    model_step(e);
    @(negedge clk);
  endtask

  task automatic rst_tick();
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.ex_rd = 0; bus.ex_MemRead = 0; bus.ex_redirect = 0; bus.imem_ready = 1;
    bus.mem_req = 0; bus.mem_ready = 1; bus.halt_req = 0; bus.resume = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst_tick();

    #1;
    chk("reset_outs", 32'(obs()), 32'(V_RUN));
    chk("reset_stall", bus.stall_cycles, 32'd0);
    chk("reset_fault", 32'(bus.mem_fault), 32'd0);
    tick("reset");

    // Load-use against rs1
    bus.ex_MemRead = 1; bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_uses_rs1 = 1;
    #1 chk("lu_outs", 32'(obs()), 32'(V_LU));
    tick("lu");
    idle_inputs();
    #1 chk("lu_stall_cnt", bus.stall_cycles, 32'd1);
    tick("post_lu");

    // x0 destination never stalls
    bus.ex_MemRead = 1; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_uses_rs1 = 1;
    #1 chk("lu_x0", 32'(obs()), 32'(V_RUN));
    tick("lu_x0");

    // Redirect overrides load-use
    bus.ex_rd = 5; bus.id_rs1 = 5; bus.ex_redirect = 1;
    #1 chk("redir_lu", 32'(obs()), 32'(V_REDIR));
    tick("redir_lu");

    // Freeze holds a pending redirect; flushes appear on release
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("freeze_redir", 32'(obs()), 32'(V_FREEZE));
      tick("freeze_redir");
    end
    bus.mem_ready = 1;
    #1 chk("release_redir", 32'(obs()), 32'(V_REDIR));
    tick("release_redir");
    idle_inputs();

    // Halt pulse, pending cycle, drain, halted, resume
    bus.halt_req = 1;
    tick("halt_req");
    bus.halt_req = 0;
    #1 chk("halt_pend_run", 32'(obs()), 32'(V_RUN));
    tick("halt_pend");
    for (int i = 0; i < DC; i++) begin
      #1 chk("drain", 32'(obs()), 32'(V_FETCH));
      tick("drain");
    end
    #1 chk("halted", 32'(obs()), 32'(V_HALT));
    tick("halted");
    bus.resume = 1;
    tick("resume");
    bus.resume = 0;
    #1 chk("resumed", 32'(obs()), 32'(V_RUN));
    chk("stall_after_halt", bus.stall_cycles, 32'd8);
    tick("resumed");

    // Data-memory timeout
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < TO; i++) tick("to_wait");
    #1 chk("to_halted", 32'(bus.halted), 32'd1);
    chk("to_fault", 32'(bus.mem_fault), 32'd1);
    tick("to_fault");
    bus.mem_req = 0; bus.mem_ready = 1; bus.resume = 1;
    tick("to_resume");
    bus.resume = 0;
    #1 chk("to_resume_ignored", 32'(bus.halted), 32'd1);
    tick("to_still_halted");
    rst_tick();
    #1 chk("rst_clr_fault", 32'(bus.mem_fault), 32'd0);
    chk("rst_clr_halt", 32'(bus.halted), 32'd0);
    tick("post_rst");

    // Fetch miss under data freeze, then alone
    bus.imem_ready = 0; bus.mem_req = 1; bus.mem_ready = 0;
    #1 chk("imem_freeze", 32'(obs()), 32'(V_FREEZE));
    tick("imem_freeze");
    bus.mem_ready = 1;
    #1 chk("imem_only", 32'(obs()), 32'(V_FETCH));
    tick("imem_only");
    idle_inputs();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.id_rs1      = 5'($urandom_range(0, 3));
      bus.id_rs2      = 5'($urandom_range(0, 3));
      bus.id_uses_rs1 = 1'($urandom_range(0, 1));
      bus.id_uses_rs2 = 1'($urandom_range(0, 1));
      bus.ex_rd       = 5'($urandom_range(0, 3));
      bus.ex_MemRead  = 1'($urandom_range(0, 1));
      bus.ex_redirect = ($urandom_range(0, 5) == 0);
      bus.imem_ready  = ($urandom_range(0, 4) != 0);
      bus.mem_req     = 1'($urandom_range(0, 1));
      bus.mem_ready   = ($urandom_range(0, 3) != 0);
      bus.halt_req    = ($urandom_range(0, 29) == 0);
      bus.resume      = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) rst_tick();
      else tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Generates per-stage register enables and flushes from four conditions: load-use hazards against the decode-stage source registers, EX-stage taken branches/jumps, instruction/data memory wait handshakes, and a debug halt request.
- Owns halt/drain sequencing, a data-memory timeout fault and a stall-cycle performance counter.

Parameters:
- DRAIN_CYCLES, 4, non-stalled cycles spent draining EX/MEM/WB after fetch is stopped, before HALTED.
- DMEM_TIMEOUT, 256, maximum consecutive data-memory wait cycles before a fault is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  5  decode-stage source register 1
- id_rs2  in  5  decode-stage source register 2
- id_uses_rs1  in  1  decode instruction reads rs1
- id_uses_rs2  in  1  decode instruction reads rs2
- ex_rd  in  5  EX-stage destination register
- ex_MemRead  in  1  EX-stage instruction is a load
- ex_redirect  in  1  EX-stage branch taken or jump, so PC is redirected
- imem_ready  in  1  fetch data valid this cycle
- mem_req  in  1  MEM stage holds a load/store
- mem_ready  in  1  data memory acknowledges the MEM-stage access
- halt_req  in  1  debug halt request, level
- resume  in  1  one-cycle pulse that leaves HALTED
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  insert a NOP into IF/ID, ID/EX or MEM/WB
- halted  out  1  controller is in HALTED
- mem_fault  out  1  sticky data-memory timeout flag
- stall_cycles  out  32  performance counter

Behaviour:
- Reset: state=RUN, drain_cnt=0, wait_cnt=0, mem_fault=0, stall_cycles=0, halt_pend=0.
- Reset outputs: all enables 1, all flushes 0, halted=0.
- Outputs are combinational from the registered state and the current inputs, so there is zero-cycle latency.
- Conditions:
  - freeze = mem_req & ~mem_ready.
  - lu = ex_MemRead & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- Priority in RUN, highest first:
  1. freeze: all enables 0, mem_wb_bubble=1, no flushes. A pending ex_redirect/lu is held in place and re-evaluated on release.
  2. ex_redirect: all enables 1, if_id_flush=1, id_ex_flush=1. This overrides lu, because the loaded-into instruction is squashed.
  3. lu: pc_en=0, if_id_en=0, id_ex_flush=1; EX/MEM/WB advance. This gives exactly one bubble per load-use.
  4. ~imem_ready: pc_en=0, if_id_flush=1; downstream stages advance.
- halt_req sampled in RUN sets halt_pend.
  - Transition to DRAIN happens on the first cycle with halt_pend & ~freeze.
  - A redirect in that same cycle still applies its flushes.
- DRAIN:
  - pc_en=0, if_id_flush=1.
  - freeze rules as in RUN.
  - drain_cnt increments on non-freeze cycles.
  - At drain_cnt==DRAIN_CYCLES-1 with ~freeze, go to HALTED and clear drain_cnt.
- HALTED:
  - All enables 0, flushes 0, halted=1.
  - resume goes to RUN and clears halt_pend.
  - resume is ignored while halt_req is still high, or while mem_fault=1.
- Timeout:
  - wait_cnt increments while freeze and clears when ~freeze.
  - If freeze persists with wait_cnt==DMEM_TIMEOUT-1, then in the next cycle mem_fault=1 and state=HALTED, from any state.
  - mem_fault is cleared only by rst.
- stall_cycles increments (wrapping at 2^32) on every cycle where pc_en=0 and state!=HALTED.
- A resume pulse outside HALTED has no effect.
- halt_req deasserted before DRAIN is entered does not cancel halt_pend.
- rst mid-drain or mid-freeze returns to reset values the next cycle.

Decomposition:
- Package pipe_ctrl_definitions: typedef enum ctrl_state_t {CTRL_RUN, CTRL_DRAIN, CTRL_HALTED}. It also holds the localparam NOP-related constants shared with the stage registers.
- One natural combinational sub-module, load_use_detect (computes lu). The FSM, counters and output priority mux stay in pipeline_ctrl.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1, stall_cycles 0->1. Repeat with ex_rd=0 -> no stall.
- Redirect and load-use together: ex_redirect=1 with the lu condition -> if_id_flush=1, id_ex_flush=1, pc_en=1.
- Data wait: mem_req=1, mem_ready=0 for 3 cycles with ex_redirect=1 -> all enables 0, mem_wb_bubble=1 for 3 cycles; flushes appear on the release cycle.
- Halt: halt_req pulse in RUN -> DRAIN for 4 cycles with pc_en=0, then halted=1; resume pulse -> RUN, all enables 1.
- Timeout: DMEM_TIMEOUT=8, hold freeze for 8 cycles -> mem_fault=1 and halted=1 on cycle 9; resume ignored; rst clears both.
- Imem miss with a concurrent data freeze: imem_ready=0 and freeze -> freeze outputs only; then imem_ready=0 alone -> if_id_flush=1, id_ex_en=1.
